// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response collector.
package puf_pkg;

  localparam int unsigned CHAL_W_DEF        = 8;
  localparam int unsigned RESP_BITS_DEF     = 8;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;
  localparam int unsigned VOTE_ROUNDS       = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // 2-of-3 vote: ones seen in the earlier rounds plus the current sample
  function automatic logic majority(input logic [1:0] ones, input logic b);
    return (3'(ones) + 3'(b)) >= 3'd2;
  endfunction

endpackage

// File: rtl/puf_settle_timer.sv
// Loadable down-counter that times how long a challenge settles before sampling.
module puf_settle_timer #(
  parameter int unsigned LOAD_VAL = 3,
  parameter int unsigned CNT_W    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(LOAD_VAL);
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/puf_response_collector.sv
// Drives challenges into the PUF core, samples each response bit after a settle window
// and delivers the assembled word over valid/ack. Define MAJORITY_VOTE_EN for 3-sample voting.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W        = CHAL_W_DEF,
  parameter int unsigned RESP_BITS     = RESP_BITS_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [CHAL_W-1:0]    Challenge,
  output logic [CHAL_W-1:0]    Puf_Challenge,
  input  logic                 Puf_Response,
  output logic                 Busy,
  output logic [RESP_BITS-1:0] Response,
  output logic                 Resp_Valid,
  input  logic                 Resp_Ack
);

  localparam int unsigned BIT_W = $clog2(RESP_BITS);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t               state, state_next;
  logic [RESP_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [CHAL_W-1:0]    chal_d;
  logic [RESP_BITS-1:0] resp_d;
  logic                 valid_d, busy_d;
  logic                 timer_load_c, timer_en_c, timer_zero_c;
  logic                 bit_ready_c, sample_bit_c;

`ifdef MAJORITY_VOTE_EN
  logic [1:0] round_q, round_d;
  logic [1:0] ones_q, ones_d;
`endif

  puf_settle_timer #(
    .LOAD_VAL (SETTLE_CYCLES - 1),
    .CNT_W    (SET_W)
  ) u_settle_timer (
    .clk    (Clock),
    .rst    (Reset),
    .load   (timer_load_c),
    .en     (timer_en_c),
    .zero_c (timer_zero_c)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      shift_q       <= '0;
      bit_q         <= '0;
      Puf_Challenge <= '0;
      Response      <= '0;
      Resp_Valid    <= 1'b0;
      Busy          <= 1'b0;
`ifdef MAJORITY_VOTE_EN
      round_q       <= '0;
      ones_q        <= '0;
`endif
    end else begin
      state         <= state_next;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      Puf_Challenge <= chal_d;
      Response      <= resp_d;
      Resp_Valid    <= valid_d;
      Busy          <= busy_d;
`ifdef MAJORITY_VOTE_EN
      round_q       <= round_d;
      ones_q        <= ones_d;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    shift_d      = shift_q;
    bit_d        = bit_q;
    chal_d       = Puf_Challenge;
    resp_d       = Response;
    timer_load_c = 1'b0;
    timer_en_c   = 1'b0;
    bit_ready_c  = 1'b0;
    sample_bit_c = Puf_Response;
`ifdef MAJORITY_VOTE_EN
    round_d      = round_q;
    ones_d       = ones_q;
`endif

    case (state)
      IDLE: begin
        if (Start) begin
          state_next = LOAD;
          bit_d      = '0;
        end
      end
      LOAD: begin
        chal_d       = Challenge;
        timer_load_c = 1'b1;
        state_next   = SETTLE;
`ifdef MAJORITY_VOTE_EN
        round_d      = '0;
        ones_d       = '0;
`endif
      end
      SETTLE: begin
        timer_en_c = 1'b1;
        if (timer_zero_c) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
`ifdef MAJORITY_VOTE_EN
        // Earlier rounds only tally and re-settle on the same challenge
        if (round_q == 2'(VOTE_ROUNDS - 1)) begin
          bit_ready_c  = 1'b1;
          sample_bit_c = majority(ones_q, Puf_Response);
        end else begin
          ones_d       = ones_q + 2'(Puf_Response);
          round_d      = round_q + 2'd1;
          timer_load_c = 1'b1;
          state_next   = SETTLE;
        end
`else
        bit_ready_c = 1'b1;
`endif
        if (bit_ready_c) begin
          shift_d = {shift_q[RESP_BITS-2:0], sample_bit_c};
          if (bit_q == BIT_W'(RESP_BITS - 1)) begin
            resp_d     = shift_d;
            state_next = DONE;
          end else begin
            bit_d      = bit_q + BIT_W'(1);
            state_next = LOAD;
          end
        end
      end
      DONE: begin
        if (Resp_Ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    valid_d = (state_next == DONE);
    busy_d  = (state_next == LOAD) || (state_next == SETTLE) || (state_next == SAMPLE);
  end

endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
Consumes the 8-bit challenge stream from the on-chip challenge generator and drives each challenge into the PUF core. For each challenge it waits a settle window, then samples the 1-bit PUF response. It assembles RESP_BITS responses into one response word and hands that word to the downstream key/ID logic over a valid/ack handshake.

Parameters:
CHAL_W, 8, width of Challenge and Puf_Challenge.
RESP_BITS, 8, number of response bits collected per run; legal range 2..32.
SETTLE_CYCLES, 4, cycles Puf_Challenge is held stable before a sample; minimum 1.

Ports:
Clock  input  1  single system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request one collection run; sampled only in IDLE.
Challenge  input  CHAL_W  current challenge from the generator (free-running).
Puf_Challenge  output  CHAL_W  registered challenge applied to the PUF core.
Puf_Response  input  1  PUF core response bit; synchronous to Clock (registered inside the PUF core).
Busy  output  1  high in LOAD, SETTLE and SAMPLE.
Response  output  RESP_BITS  assembled response word; updated only on run completion.
Resp_Valid  output  1  high in DONE.
Resp_Ack  input  1  consumer accepts Response.

Behaviour:
- Reset (async, active-high): state=IDLE; Puf_Challenge=0; Response=0; Resp_Valid=0; Busy=0; shift register, bit counter and settle counter cleared. Reset mid-run aborts the run and drops any partial word.
- State machine: IDLE, LOAD, SETTLE, SAMPLE, DONE.
- IDLE: Start=1 → LOAD; bit counter=0.
- LOAD (1 cycle): Puf_Challenge <= Challenge (fresh generator value for every bit); settle counter <= SETTLE_CYCLES-1 → SETTLE.
- SETTLE: if counter==0 → SAMPLE, else decrement. Dwell is exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): shift register <= {shift[RESP_BITS-2:0], Puf_Response}, so the first bit ends up at the MSB. If bit counter==RESP_BITS-1: Response <= final word, go to DONE. Otherwise increment the counter and go to LOAD.
- DONE: Resp_Valid=1 and Response stable. Resp_Ack=1 → IDLE on the next edge. Response retains its value after the ack until the next run completes.
- Per-bit cost is SETTLE_CYCLES+2 cycles. Resp_Valid rises RESP_BITS*(SETTLE_CYCLES+2) edges after the edge that sampled Start (defaults: 48).
- Start outside IDLE is ignored, with no queuing. Start and Resp_Ack together in DONE: the ack wins, the FSM goes to IDLE, and Start must be reasserted.
- Resp_Ack outside DONE is ignored.
- Puf_Challenge holds its last value in IDLE and DONE.

Optional Feature:
MAJORITY_VOTE_EN
- Defined: each challenge is loaded once. SETTLE→SAMPLE is then repeated 3 times with the same Puf_Challenge.
- The shifted bit is the 2-of-3 majority of the three samples.
- Per-bit cost is 1+3*(SETTLE_CYCLES+1) cycles; the default total is 128.
- A 2-bit vote-round counter and a 2-bit ones tally are added. Both are cleared in LOAD and on reset.
- Undefined: single sample per challenge as above, and no vote logic is present.

Decomposition:
- Shared package puf_pkg holds:
  - state enum (IDLE, LOAD, SETTLE, SAMPLE, DONE)
  - default CHAL_W/RESP_BITS/SETTLE_CYCLES constants
  - VOTE_ROUNDS=3
- One natural sub-module, puf_settle_timer: a loadable down-counter with load, enable and a zero flag, used for the SETTLE dwell.
- The majority function is an inline function in puf_pkg.

Test Plan:
1. Reset check: assert Reset asynchronously mid-cycle → Response=0, Resp_Valid=0, Busy=0 and Puf_Challenge=0 immediately, before the next clock edge.
2. Default run with a PUF model where response = XOR-reduce(Puf_Challenge) and a generator counting from 0x00 → Resp_Valid at edge 48. Response equals the parity bits of the 8 challenges latched in each LOAD, first bit at MSB. Busy is high for exactly 48 cycles.
3. Pulse Start again at cycles 5 and 20 of a run → ignored; exactly one completion occurs at edge 48.
4. Hold Resp_Ack low for 10 cycles in DONE → Resp_Valid and Response stay stable. Assert Resp_Ack together with Start → IDLE, no new run, Response unchanged.
5. Assert Reset at cycle 30 of a run, then Start again → the new run completes at edge 48 after its Start. The aborted run leaves no partial bits in Response.
6. With MAJORITY_VOTE_EN and a model that flips one of the three samples per bit (pattern 1,0,1 for a true 1) → Response equals the true parity word, and Resp_Valid at edge 128.
